mux4_rr_arb: RTL and testbench

MUX4_RR_ARB -- requirements
Module: mux4_rr_arb

---
 rtl/mux4_rr_arb.sv | 127 ++++++++++++
 tb/tb_mux4_rr_arb.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arb.sv
// Four-input round-robin arbiter/mux with ready/valid output and grant timeout.
// One transfer at a time; every completion or timeout returns through IDLE.
module mux4_rr_arb #(
  parameter int DW = 8,
  parameter int TO = 15
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic [3:0]    i_req,
  input  logic [DW-1:0] i_in0,
  input  logic [DW-1:0] i_in1,
  input  logic [DW-1:0] i_in2,
  input  logic [DW-1:0] i_in3,
  input  logic          i_ready,
  output logic [3:0]    o_gnt,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_err
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] TO_CNT = 8'(TO);

  state_t     state, state_n;
  logic [3:0] gnt_n;
  logic       valid_n;
  logic       err_n;
  logic [1:0] ptr, ptr_n;
  logic [1:0] gidx, gidx_n;
  logic [7:0] stall_cnt, stall_cnt_n;

  logic [1:0] pick_idx;
  logic       pick_hit;
  logic [1:0] cand;

  // Search starts just after the last served index so it has lowest priority.
  always_comb begin
    pick_idx = '0;
    pick_hit = 1'b0;
    cand     = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!pick_hit && i_req[cand]) begin
        pick_hit = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    state_n     = state;
    gnt_n       = o_gnt;
    valid_n     = o_valid;
    err_n       = 1'b0;
    ptr_n       = ptr;
    gidx_n      = gidx;
    stall_cnt_n = stall_cnt;
    case (state)
      IDLE: begin
        if (pick_hit) begin
          state_n     = GRANT;
          gidx_n      = pick_idx;
          gnt_n       = 4'b0001 << pick_idx;
          valid_n     = 1'b1;
          stall_cnt_n = '0;
        end
      end
      GRANT: begin
        // Handshake wins over a timeout landing in the same cycle.
        if (i_ready) begin
          state_n = IDLE;
          gnt_n   = '0;
          valid_n = 1'b0;
          ptr_n   = gidx;
        end else if ((TO != 0) && (stall_cnt == TO_CNT)) begin
          state_n = IDLE;
          gnt_n   = '0;
          valid_n = 1'b0;
          ptr_n   = gidx;
          err_n   = 1'b1;
        end else if (stall_cnt != 8'hFF) begin
          stall_cnt_n = stall_cnt + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state     <= IDLE;
      o_gnt     <= '0;
      o_valid   <= 1'b0;
      o_err     <= 1'b0;
      ptr       <= 2'd3;
      gidx      <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_n;
      o_gnt     <= gnt_n;
      o_valid   <= valid_n;
      o_err     <= err_n;
      ptr       <= ptr_n;
      gidx      <= gidx_n;
      stall_cnt <= stall_cnt_n;
    end
  end

  // Data follows the granted input live and is forced to zero when not offered.
  always_comb begin
    o_data = '0;
    if (o_valid) begin
      case (gidx)
        2'd0:    o_data = i_in0;
        2'd1:    o_data = i_in1;
        2'd2:    o_data = i_in2;
        default: o_data = i_in3;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arb.sv
// Directed bench for mux4_rr_arb; four instances with TO = 15, 3, 2 and 0
// share the same stimulus, and each scenario checks the instance it targets.
module tb_mux4_rr_arb;

  logic       clk;
  logic       rstn;
  logic [3:0] req;
  logic [7:0] in0, in1, in2, in3;
  logic       ready;

  logic [3:0] gnt15, gnt3, gnt2, gnt0;
  logic       valid15, valid3, valid2, valid0;
  logic [7:0] data15, data3, data2, data0;
  logic       err15, err3, err2, err0;

  int checks = 0;
  int errors = 0;

  mux4_rr_arb #(.DW(8), .TO(15)) u15 (
    .i_clk(clk), .i_rstn(rstn), .i_req(req), .i_in0(in0), .i_in1(in1),
    .i_in2(in2), .i_in3(in3), .i_ready(ready), .o_gnt(gnt15),
    .o_valid(valid15), .o_data(data15), .o_err(err15));

  mux4_rr_arb #(.DW(8), .TO(3)) u3 (
    .i_clk(clk), .i_rstn(rstn), .i_req(req), .i_in0(in0), .i_in1(in1),
    .i_in2(in2), .i_in3(in3), .i_ready(ready), .o_gnt(gnt3),
    .o_valid(valid3), .o_data(data3), .o_err(err3));

  mux4_rr_arb #(.DW(8), .TO(2)) u2 (
    .i_clk(clk), .i_rstn(rstn), .i_req(req), .i_in0(in0), .i_in1(in1),
    .i_in2(in2), .i_in3(in3), .i_ready(ready), .o_gnt(gnt2),
    .o_valid(valid2), .o_data(data2), .o_err(err2));

  mux4_rr_arb #(.DW(8), .TO(0)) u0 (
    .i_clk(clk), .i_rstn(rstn), .i_req(req), .i_in0(in0), .i_in1(in1),
    .i_in2(in2), .i_in3(in3), .i_ready(ready), .o_gnt(gnt0),
    .o_valid(valid0), .o_data(data0), .o_err(err0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are observed 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn  = 1'b0;
    req   = 4'b0000;
    ready = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn  = 1'b0;
    req   = 4'b1111;
    ready = 1'b1;
    tick();
    tick();
    checks++;
    if ({gnt15, valid15, data15, err15} !== 14'd0) begin
      errors++;
      $display("[TB] FAIL reset_u15: got gnt=%b valid=%b data=%h err=%b, expected all zero",
               gnt15, valid15, data15, err15);
    end
    checks++;
    if ({gnt3, valid3, data3, err3, gnt2, valid2, data2, err2} !== 28'd0) begin
      errors++;
      $display("[TB] FAIL reset_u3_u2: got gnt3=%b valid3=%b gnt2=%b valid2=%b, expected zero",
               gnt3, valid3, gnt2, valid2);
    end
    rstn  = 1'b1;
    req   = 4'b0000;
    ready = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    in0   = 8'hA5;
    req   = 4'b0001;
    ready = 1'b1;
    checks++;
    if (valid15 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_latency: got valid=%b, expected 0", valid15);
    end
    tick();
    req = 4'b0000;
    checks++;
    if (gnt15 !== 4'b0001 || valid15 !== 1'b1 || data15 !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL single_grant: got gnt=%b valid=%b data=%h, expected 0001 1 a5",
               gnt15, valid15, data15);
    end
    tick();
    checks++;
    if (gnt15 !== 4'b0000 || valid15 !== 1'b0 || data15 !== 8'h00) begin
      errors++;
      $display("[TB] FAIL single_idle: got gnt=%b valid=%b data=%h, expected 0000 0 00",
               gnt15, valid15, data15);
    end
  endtask

  task automatic test_rotation();
    logic [1:0] order [5];
    logic [3:0] exp_gnt;
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    req   = 4'b1111;
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_gnt = 4'b0001 << order[i];
      tick();
      checks++;
      if (gnt15 !== exp_gnt || valid15 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rotation_grant%0d: got gnt=%b valid=%b, expected %b 1",
                 i, gnt15, valid15, exp_gnt);
      end
      tick();
      checks++;
      if (gnt15 !== 4'b0000 || valid15 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rotation_bubble%0d: got gnt=%b valid=%b, expected 0000 0",
                 i, gnt15, valid15);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_backpressure();
    do_reset();
    in2   = 8'h10;
    req   = 4'b0100;
    ready = 1'b0;
    tick();
    req = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      in2 = 8'h20 + 8'(i);
      if (i == 5) ready = 1'b1;
      #1;
      checks++;
      if (gnt15 !== 4'b0100 || valid15 !== 1'b1 || data15 !== (8'h20 + 8'(i)) || err15 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL backpressure_hold%0d: got gnt=%b valid=%b data=%h err=%b, expected 0100 1 %h 0",
                 i, gnt15, valid15, data15, err15, 8'h20 + 8'(i));
      end
      tick();
    end
    req = 4'b0000;
    checks++;
    if (valid15 !== 1'b0 || gnt15 !== 4'b0000 || err15 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL backpressure_done: got gnt=%b valid=%b err=%b, expected 0000 0 0",
               gnt15, valid15, err15);
    end
    ready = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    req   = 4'b0010;
    ready = 1'b0;
    tick();
    req = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (gnt3 !== 4'b0010 || valid3 !== 1'b1 || err3 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL timeout_stall%0d: got gnt=%b valid=%b err=%b, expected 0010 1 0",
                 i, gnt3, valid3, err3);
      end
      tick();
    end
    checks++;
    if (err3 !== 1'b1 || valid3 !== 1'b0 || gnt3 !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL timeout_pulse: got err=%b valid=%b gnt=%b, expected 1 0 0000",
               err3, valid3, gnt3);
    end
    checks++;
    if (gnt0 !== 4'b0010 || valid0 !== 1'b1 || err0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_disabled_hold: got gnt=%b valid=%b err=%b, expected 0010 1 0",
               gnt0, valid0, err0);
    end
    tick();
    checks++;
    if (err3 !== 1'b0 || gnt3 !== 4'b0001 || valid3 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_next_grant: got err=%b gnt=%b valid=%b, expected 0 0001 1",
               err3, gnt3, valid3);
    end
    req = 4'b0000;
  endtask

  task automatic test_collision();
    do_reset();
    req   = 4'b0001;
    ready = 1'b0;
    tick();
    req = 4'b0000;
    tick();
    tick();
    checks++;
    if (gnt2 !== 4'b0001 || valid2 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL collision_pending: got gnt=%b valid=%b, expected 0001 1", gnt2, valid2);
    end
    ready = 1'b1;
    tick();
    checks++;
    if (err2 !== 1'b0 || valid2 !== 1'b0 || gnt2 !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL collision_complete: got err=%b valid=%b gnt=%b, expected 0 0 0000",
               err2, valid2, gnt2);
    end
    tick();
    checks++;
    if (err2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL collision_no_err: got err=%b, expected 0", err2);
    end
    ready = 1'b0;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    in0   = 8'h5A;
    req   = 4'b0001;
    ready = 1'b0;
    tick();
    checks++;
    if (valid15 !== 1'b1 || data15 !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL midreset_pre: got valid=%b data=%h, expected 1 5a", valid15, data15);
    end
    rstn = 1'b0;
    tick();
    checks++;
    if (gnt15 !== 4'b0000 || valid15 !== 1'b0 || data15 !== 8'h00 || err15 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_clear: got gnt=%b valid=%b data=%h err=%b, expected 0000 0 00 0",
               gnt15, valid15, data15, err15);
    end
    rstn = 1'b1;
    req  = 4'b1000;
    tick();
    checks++;
    if (gnt15 !== 4'b1000 || valid15 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_grant3: got gnt=%b valid=%b, expected 1000 1", gnt15, valid15);
    end
    ready = 1'b1;
    req   = 4'b0000;
    tick();
    req = 4'b1001;
    tick();
    checks++;
    if (gnt15 !== 4'b0001 || valid15 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_grant0: got gnt=%b valid=%b, expected 0001 1", gnt15, valid15);
    end
    req   = 4'b0000;
    ready = 1'b0;
  endtask

  initial begin
    rstn  = 1'b0;
    req   = 4'b0000;
    ready = 1'b0;
    in0   = 8'h00;
    in1   = 8'h11;
    in2   = 8'h22;
    in3   = 8'h33;
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_timeout();
    test_collision();
    test_reset_mid_grant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
